// File: rtl/uart_bus_periph.sv
// UART peripheral on an 8-bit async CPU bus: tick divider, strobe sync,
// TX framer (1 idle, start, 8 data, 2 stop) and 16x oversampled RX.
module uart_bus_periph #(
    parameter int          TICK_DIV = 17,
    parameter logic [7:0]  ID_VALUE = 8'h51
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       ncs,
    input  logic       rw,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       tx,
    input  logic       rx,
    output logic       baud_tick
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE, START, DATA, STOP
    } rx_state_t;

    logic [DW-1:0] div_cnt;
    logic [3:0]    phase;
    logic          bit_edge;

    logic [2:0]    wr_sync;
    logic [2:0]    rd_sync;
    logic          wr_pulse;
    logic          rd_pulse;

    logic [11:0]   shift;
    logic [3:0]    bits_left;
    logic          tx_busy;

    logic [1:0]    rx_sync;
    logic          rx_s;
    rx_state_t     state;
    logic [3:0]    tcnt;
    logic [2:0]    bcnt;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_overrun;
    logic          frame_err;

    assign baud_tick = (div_cnt == LAST);
    assign bit_edge  = baud_tick & (phase == 4'hF);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_cnt <= '0;
            phase   <= '0;
        end else begin
            div_cnt <= baud_tick ? '0 : div_cnt + 1'b1;
            if (baud_tick)
                phase <= phase + 4'd1;
        end
    end

    // Bus strobes are async to clk; edge of the synced level is the event.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_sync <= '0;
            rd_sync <= '0;
        end else begin
            wr_sync <= {wr_sync[1:0], ~ncs & ~rw};
            rd_sync <= {rd_sync[1:0], ~ncs & rw};
        end
    end

    assign wr_pulse = wr_sync[1] & ~wr_sync[2];
    assign rd_pulse = rd_sync[1] & ~rd_sync[2];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shift     <= '1;
            bits_left <= '0;
        end else if (wr_pulse && addr == 2'd0 && bits_left == 4'd0) begin
            shift     <= {2'b11, data_in, 2'b01};
            bits_left <= 4'd12;
        end else if (bit_edge && bits_left != 4'd0) begin
            shift     <= {1'b1, shift[11:1]};
            bits_left <= bits_left - 4'd1;
        end
    end

    assign tx      = shift[0];
    assign tx_busy = (bits_left != 4'd0);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            rx_sync <= 2'b11;
        else
            rx_sync <= {rx_sync[0], rx};
    end

    assign rx_s = rx_sync[1];

    // Flag clears come first so a set in the same cycle overrides them.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            tcnt       <= '0;
            bcnt       <= '0;
            rx_shift   <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (rd_pulse && addr == 2'd0) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
            if (rd_pulse && addr == 2'd1)
                frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        tcnt  <= '0;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        if (tcnt == 4'd7) begin
                            tcnt  <= '0;
                            bcnt  <= '0;
                            state <= rx_s ? IDLE : DATA;
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (tcnt == 4'd15) begin
                            tcnt     <= '0;
                            rx_shift <= {rx_s, rx_shift[7:1]};
                            bcnt     <= bcnt + 3'd1;
                            if (bcnt == 3'd7)
                                state <= STOP;
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (tcnt == 4'd15) begin
                            tcnt  <= '0;
                            state <= IDLE;
                            if (rx_s) begin
                                rx_data  <= rx_shift;
                                rx_valid <= 1'b1;
                                if (rx_valid)
                                    rx_overrun <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign data_oe = ~ncs & rw;

    always_comb begin
        data_out = 8'h00;
        if (data_oe) begin
            unique case (addr)
                2'd0: data_out = rx_data;
                2'd1: data_out = {4'b0, frame_err, rx_overrun,
                                  rx_valid, tx_busy};
                2'd2: data_out = ID_VALUE;
                default: data_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_periph.sv
// Bench for uart_bus_periph: register table after reset, TX bit
// scoreboard, RX frames, overrun, framing error, glitch, async reset.
module tb_uart_bus_periph;

    localparam int BIT = 16 * 17;

    logic       clk = 1'b0;
    logic       nrst;
    logic       ncs;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       tx;
    logic       rx;
    logic       baud_tick;

    int checks = 0;
    int errors = 0;

    logic tx_q[$];
    logic [7:0] rx_q[$];

    typedef struct {
        logic [1:0] a;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[4];

    uart_bus_periph dut (
        .clk(clk), .nrst(nrst), .ncs(ncs), .rw(rw), .addr(addr),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .tx(tx), .rx(rx), .baud_tick(baud_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] v,
                            output logic oe);
        @(negedge clk);
        ncs = 1'b0; rw = 1'b1; addr = a;
        #1;
        v = data_out;
        oe = data_oe;
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        ncs = 1'b0; rw = 1'b0; addr = a; data_in = d;
        repeat (4) @(negedge clk);
        ncs = 1'b1; rw = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic read_chk(input string nm, input logic [1:0] a,
                            input logic [7:0] exp);
        logic [7:0] v;
        logic oe;
        bus_read(a, v, oe);
        chk(nm, v, exp);
        chk({nm, "_oe"}, {7'b0, oe}, 8'h01);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_ok);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        if (stop_ok) begin
            rx = 1'b1;
            repeat (BIT) @(negedge clk);
            rx_q.push_back(b);
        end else begin
            // Short low stop so the tail cannot look like a new start.
            rx = 1'b0;
            repeat (180) @(negedge clk);
            rx = 1'b1;
            repeat (300) @(negedge clk);
        end
        repeat (100) @(negedge clk);
    endtask

    task automatic read_rx(input string nm);
        logic [7:0] exp;
        exp = 8'h00;
        if (rx_q.size() != 0)
            exp = rx_q[$];
        rx_q.delete();
        read_chk(nm, 2'd0, exp);
    endtask

    task automatic tx_monitor();
        int n;
        logic e;
        n = 0;
        while (tx !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL tx_start got=timeout want=fall");
            tx_q.delete();
        end else begin
            repeat (BIT / 2) @(negedge clk);
            while (tx_q.size() != 0) begin
                e = tx_q.pop_front();
                chk("tx_bit", {7'b0, tx}, {7'b0, e});
                repeat (BIT) @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] v;
        logic oe;
        int lows;

        tbl[0] = '{2'd0, 8'h00};
        tbl[1] = '{2'd1, 8'h00};
        tbl[2] = '{2'd2, 8'h51};
        tbl[3] = '{2'd3, 8'h00};

        nrst = 1'b0; ncs = 1'b1; rw = 1'b1; addr = 2'd0;
        data_in = 8'h00; rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", {7'b0, tx}, 8'h01);
        chk("rst_tick", {7'b0, baud_tick}, 8'h00);
        chk("rst_oe", {7'b0, data_oe}, 8'h00);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_dout", data_out, 8'h00);

        for (int i = 0; i < 4; i++)
            read_chk($sformatf("reg%0d", tbl[i].a), tbl[i].a, tbl[i].exp);

        bus_write(2'd1, 8'hFF);
        bus_write(2'd2, 8'h00);
        read_chk("wr_ignored", 2'd1, 8'h00);

        d = 8'hA5;
        tx_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            tx_q.push_back(d[i]);
        tx_q.push_back(1'b1);
        tx_q.push_back(1'b1);
        fork
            tx_monitor();
            begin
                bus_write(2'd0, 8'hA5);
                bus_write(2'd0, 8'h3C);
                read_chk("busy", 2'd1, 8'h01);
            end
        join
        repeat (BIT) @(negedge clk);
        read_chk("tx_done", 2'd1, 8'h00);
        lows = 0;
        repeat (3 * BIT) begin
            @(negedge clk);
            if (tx !== 1'b1)
                lows++;
        end
        chk("no_2nd_frame", lows[7:0], 8'h00);

        send_rx(8'h5A, 1'b1);
        read_chk("rx_valid", 2'd1, 8'h02);
        read_rx("rx_data");
        read_chk("rx_clr", 2'd1, 8'h00);

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        read_chk("overrun", 2'd1, 8'h06);
        read_rx("rx_last");
        read_chk("ovr_clr", 2'd1, 8'h00);

        send_rx(8'h77, 1'b0);
        read_chk("frame_err", 2'd1, 8'h08);
        read_chk("ferr_clr", 2'd1, 8'h00);

        @(negedge clk);
        rx = 1'b0;
        repeat (51) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        read_chk("glitch", 2'd1, 8'h00);

        bus_write(2'd0, 8'h00);
        repeat (1000) @(negedge clk);
        ncs = 1'b0; rw = 1'b1; addr = 2'd1;
        #1;
        chk("mid_busy", data_out, 8'h01);
        nrst = 1'b0;
        #1;
        chk("abort_tx", {7'b0, tx}, 8'h01);
        chk("abort_busy", data_out, 8'h00);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        ncs = 1'b1;
        repeat (10) @(negedge clk);
        bus_read(2'd1, v, oe);
        chk("post_abort", v, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
